scc_mc_seq: RTL and testbench

SCC_MC_SEQ -- requirements
Module: scc_mc_seq

---
 rtl/scc_mc_seq.sv | 201 ++++++++++++++++++++
 tb/tb_scc_mc_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scc_mc_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WB control with
// instruction and data memory handshakes, bounded handshake waits, sticky
// HALT/FAULT, and a retired-instruction counter.
module scc_mc_seq #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          PC_STEP  = 4,
  parameter int unsigned          TIMEOUT  = 16,
  parameter int unsigned          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_s,
  input  logic [DATA_W-1:0] in_mem,
  input  logic              in_mem_valid,
  output logic [ADDR_W-1:0] in_mem_addr,
  output logic              in_mem_en,
  output logic [DATA_W-1:0] ir,
  input  logic              dec_mem_rd,
  input  logic              dec_mem_wr,
  input  logic              dec_reg_wr,
  input  logic              dec_cpsr_wr,
  input  logic              dec_halt,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              data_read,
  output logic              data_write,
  input  logic              data_ack,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] mem_data,
  output logic              reg_wr_en,
  output logic              cpsr_wr_en,
  output logic              halted,
  output logic              fault,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned       WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5,
    S_FAULT   = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ld_q, ld_d;
  logic              st_q, st_d;
  logic              rw_q, rw_d;
  logic              cw_q, cw_d;
  logic              br_q, br_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              timeout_hit;

  assign timeout_hit = (wait_q == WAIT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_s) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack in the last allowed wait cycle beats the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (in_mem_valid)     state_d = S_DECODE;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (dec_halt)                      state_d = S_HALT;
        else if (dec_mem_rd || dec_mem_wr) state_d = S_MEM;
        else                               state_d = S_WB;
      end
      S_MEM: begin
        if (data_ack)         state_d = S_WB;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = state_q;
    endcase
  end

  // Output decode from current state and the attributes captured in EXECUTE
  always_comb begin
    in_mem_en  = (state_q == S_FETCH);
    data_read  = (state_q == S_MEM) && ld_q;
    data_write = (state_q == S_MEM) && st_q;
    reg_wr_en  = (state_q == S_WB) && rw_q;
    cpsr_wr_en = (state_q == S_WB) && cw_q;
  end

  // Datapath next-state: wait counter clears on every state change, so it
  // starts at zero on each entry to FETCH or MEM
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    mem_data_d = mem_data_q;
    retired_d  = retired_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    wait_d     = wait_q;
    ld_d       = ld_q;
    st_d       = st_q;
    rw_d       = rw_q;
    cw_d       = cw_q;
    br_d       = br_q;
    tgt_d      = tgt_q;

    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == S_FETCH) || (state_q == S_MEM)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    case (state_q)
      S_FETCH: begin
        if (in_mem_valid) ir_d = in_mem;
        if (state_d == S_FAULT) fault_d = 1'b1;
      end
      S_EXECUTE: begin
        ld_d  = dec_mem_rd;
        st_d  = dec_mem_wr && !dec_mem_rd;
        rw_d  = dec_reg_wr;
        cw_d  = dec_cpsr_wr;
        br_d  = br_taken;
        tgt_d = br_target;
        if (dec_halt) halted_d = 1'b1;
      end
      S_MEM: begin
        if (data_ack && ld_q) mem_data_d = data_in;
        if (state_d == S_FAULT) fault_d = 1'b1;
      end
      S_WB: begin
        pc_d      = br_q ? tgt_q : (pc_q + ADDR_W'(PC_STEP));
        retired_d = retired_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset_s) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      mem_data_q <= '0;
      retired_q  <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      wait_q     <= '0;
      ld_q       <= 1'b0;
      st_q       <= 1'b0;
      rw_q       <= 1'b0;
      cw_q       <= 1'b0;
      br_q       <= 1'b0;
      tgt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mem_data_q <= mem_data_d;
      retired_q  <= retired_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
      wait_q     <= wait_d;
      ld_q       <= ld_d;
      st_q       <= st_d;
      rw_q       <= rw_d;
      cw_q       <= cw_d;
      br_q       <= br_d;
      tgt_q      <= tgt_d;
    end
  end

  assign in_mem_addr = pc_q;
  assign ir          = ir_q;
  assign mem_data    = mem_data_q;
  assign retired     = retired_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign state       = state_q;

endmodule

// File: tb/tb_scc_mc_seq.sv
// Scoreboard bench for scc_mc_seq: the driver pushes expected fetch and
// writeback records, a monitor pops them when the DUT shows DECODE or WB.
module tb_scc_mc_seq;

  localparam logic [31:0] K = 32'h5A0F_3C00;

  logic        clk = 1'b0;
  logic        reset_s;
  logic [31:0] in_mem;
  logic        in_mem_valid;
  logic [31:0] in_mem_addr;
  logic        in_mem_en;
  logic [31:0] ir;
  logic        dec_mem_rd, dec_mem_wr, dec_reg_wr, dec_cpsr_wr, dec_halt;
  logic        br_taken;
  logic [31:0] br_target;
  logic        data_read, data_write, data_ack;
  logic [31:0] data_in;
  logic [31:0] mem_data;
  logic        reg_wr_en, cpsr_wr_en, halted, fault;
  logic [2:0]  state;
  logic [15:0] retired;

  always #5 clk = ~clk;

  scc_mc_seq #(
    .DATA_W(32), .ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(4),
    .TIMEOUT(16), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_s(reset_s), .in_mem(in_mem), .in_mem_valid(in_mem_valid),
    .in_mem_addr(in_mem_addr), .in_mem_en(in_mem_en), .ir(ir),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_reg_wr(dec_reg_wr),
    .dec_cpsr_wr(dec_cpsr_wr), .dec_halt(dec_halt), .br_taken(br_taken),
    .br_target(br_target), .data_read(data_read), .data_write(data_write),
    .data_ack(data_ack), .data_in(data_in), .mem_data(mem_data),
    .reg_wr_en(reg_wr_en), .cpsr_wr_en(cpsr_wr_en), .halted(halted),
    .fault(fault), .state(state), .retired(retired)
  );

  typedef struct { logic [31:0] addr; int unsigned gap; } fetch_t;
  typedef struct {
    logic [31:0] ir; logic rw; logic cw; logic [31:0] md; logic [15:0] ret;
    int unsigned rd; int unsigned wr; int unsigned lat;
  } wb_t;

  fetch_t fq[$];
  wb_t    wq[$];
  int unsigned n_cmp = 0, n_err = 0, stray = 0;
  int unsigned cyc = 0, last_dec = 0, rd_cnt = 0, wr_cnt = 0;
  int unsigned ack_dly = 0, mk = 0;
  logic [31:0] md_m = '0;
  logic [15:0] ret_m = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instruction word derives from its address; data memory acks after ack_dly waits
  always @(negedge clk) begin
    in_mem = in_mem_addr ^ K;
    if (data_read || data_write) begin
      mk++;
      data_ack = (mk == ack_dly + 1);
    end else begin
      mk = 0;
      data_ack = 1'b0;
    end
  end

  // Monitor: check fetch records on DECODE and writeback records on WB
  always begin : monitor
    fetch_t f;
    wb_t    w;
    @(posedge clk);
    #1;
    cyc++;
    if (data_read)  rd_cnt++;
    if (data_write) wr_cnt++;
    if (state != 3'd4 && (reg_wr_en || cpsr_wr_en)) stray++;
    if (state == 3'd1) begin
      if (fq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL fetch_unexpected: got fetch of 0x%0h, expected none", in_mem_addr);
      end else begin
        f = fq.pop_front();
        chk("fetch_addr", in_mem_addr, f.addr);
        chk("fetch_ir", ir, f.addr ^ K);
        if (f.gap != 0) chk("fetch_gap", cyc - last_dec, f.gap);
      end
      last_dec = cyc;
      rd_cnt = 0;
      wr_cnt = 0;
    end
    if (state == 3'd4) begin
      if (wq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL wb_unexpected: got WB at pc 0x%0h, expected none", in_mem_addr);
      end else begin
        w = wq.pop_front();
        chk("wb_ir", ir, w.ir);
        chk("wb_reg_wr_en", reg_wr_en, w.rw);
        chk("wb_cpsr_wr_en", cpsr_wr_en, w.cw);
        chk("wb_mem_data", mem_data, w.md);
        chk("wb_retired", retired, w.ret);
        chk("wb_read_cycles", rd_cnt, w.rd);
        chk("wb_write_cycles", wr_cnt, w.wr);
        chk("wb_latency", cyc - last_dec, w.lat);
      end
    end
  end

  task automatic wait_state(input logic [2:0] s, input int unsigned lim, input string nm,
                            output int unsigned n);
    n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      n++;
      if (state == s) break;
      if (n >= lim) begin
        n_cmp++; n_err++;
        $display("FAIL %s: got state %0d after %0d cycles, expected %0d", nm, state, n, s);
        break;
      end
    end
  endtask

  task automatic issue(input logic [31:0] exp_addr, input int unsigned gap,
                       input logic rd, input logic wr, input logic rw, input logic cw,
                       input logic br, input logic [31:0] tgt,
                       input int unsigned dly, input logic [31:0] din);
    fetch_t f;
    wb_t w;
    int unsigned m, n;
    dec_mem_rd = rd; dec_mem_wr = wr; dec_reg_wr = rw; dec_cpsr_wr = cw;
    dec_halt = 1'b0; br_taken = br; br_target = tgt;
    ack_dly = dly; data_in = din; in_mem_valid = 1'b1;
    m = (rd || wr) ? dly + 1 : 0;
    if (rd) md_m = din;
    f.addr = exp_addr; f.gap = gap;
    fq.push_back(f);
    w.ir = exp_addr ^ K; w.rw = rw; w.cw = cw; w.md = md_m; w.ret = ret_m;
    w.rd = rd ? m : 0; w.wr = (wr && !rd) ? m : 0; w.lat = 2 + m;
    wq.push_back(w);
    ret_m++;
    wait_state(3'd4, 40 + dly, "wb_timeout", n);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_s = 1'b0; in_mem_valid = 1'b0;
    dec_mem_rd = 0; dec_mem_wr = 0; dec_reg_wr = 0; dec_cpsr_wr = 0; dec_halt = 0;
    br_taken = 0; br_target = '0;
    @(negedge clk);
    reset_s = 1'b1;
    ret_m = '0; md_m = '0;
  endtask

  task automatic end_group(input logic [15:0] exp_ret, input logic [31:0] exp_addr);
    in_mem_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("grp_state", state, 3'd0);
    chk("grp_retired", retired, exp_ret);
    chk("grp_next_pc", in_mem_addr, exp_addr);
    chk("grp_fault", fault, 1'b0);
    do_reset();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int unsigned n;
    reset_s = 1'b0; in_mem = '0; in_mem_valid = 1'b0;
    dec_mem_rd = 0; dec_mem_wr = 0; dec_reg_wr = 0; dec_cpsr_wr = 0; dec_halt = 0;
    br_taken = 0; br_target = '0; data_ack = 0; data_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_pc", in_mem_addr, 32'h0);
    chk("rst_in_mem_en", in_mem_en, 1'b1);
    chk("rst_ir", ir, 32'h0);
    chk("rst_mem_data", mem_data, 32'h0);
    chk("rst_retired", retired, 16'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_data_rw", {data_read, data_write}, 2'b00);
    reset_s = 1'b1;

    // ALU ops back to back: fetches 0,4,8 four cycles apart
    issue(32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    issue(32'h4, 4, 0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
    issue(32'h8, 4, 0, 0, 1, 1, 0, 32'h0, 0, 32'h0);
    end_group(16'd3, 32'hC);

    // Load (3 wait cycles), store (no wait), rd+wr at the last allowed wait
    issue(32'h0, 0, 1, 0, 1, 0, 0, 32'h0, 3, 32'hDEADBEEF);
    issue(32'h4, 8, 0, 1, 0, 1, 0, 32'h0, 0, 32'h12345678);
    issue(32'h8, 5, 1, 1, 1, 0, 0, 32'h0, 15, 32'hA5A55A5A);
    end_group(16'd3, 32'hC);

    // Branches and PC wrap
    issue(32'h0,        0, 0, 0, 1, 0, 1, 32'h100,      0, 32'h0);
    issue(32'h100,      4, 0, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 32'h0);
    issue(32'hFFFFFFFC, 4, 0, 0, 1, 0, 0, 32'h0,        0, 32'h0);
    issue(32'h0,        4, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0);
    end_group(16'd4, 32'h4);

    // HALT with a store also decoded
    issue(32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    begin
      fetch_t f;
      f.addr = 32'h4; f.gap = 4;
      fq.push_back(f);
    end
    dec_halt = 1'b1; dec_mem_wr = 1'b1; dec_reg_wr = 1'b1; dec_mem_rd = 1'b0;
    in_mem_valid = 1'b1;
    wait_state(3'd5, 20, "halt_timeout", n);
    chk("halt_halted", halted, 1'b1);
    chk("halt_retired", retired, 16'd1);
    chk("halt_in_mem_en", in_mem_en, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("halt_absorbing", state, 3'd5);
    chk("halt_pc_frozen", in_mem_addr, 32'h4);
    chk("halt_ir_frozen", ir, 32'h4 ^ K);
    chk("halt_no_write", wr_cnt, 0);
    chk("halt_retired_hold", retired, 16'd1);
    do_reset();
    #1;
    chk("halt_rst_pc", in_mem_addr, 32'h0);
    chk("halt_rst_halted", halted, 1'b0);
    chk("halt_rst_state", state, 3'd0);

    // Fetch never acked: FAULT after 16 FETCH cycles, later acks ignored
    wait_state(3'd6, 40, "fault_timeout", n);
    chk("fault_cycles", n, 16);
    chk("fault_flag", fault, 1'b1);
    chk("fault_halted", halted, 1'b0);
    @(negedge clk);
    in_mem_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("fault_absorbing", state, 3'd6);
    chk("fault_ir_frozen", ir, 32'h0);
    chk("fault_pc_frozen", in_mem_addr, 32'h0);
    chk("fault_in_mem_en", in_mem_en, 1'b0);
    do_reset();
    #1;
    chk("fault_rst_fault", fault, 1'b0);

    // Reset in the middle of a store
    issue(32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    begin
      fetch_t f;
      f.addr = 32'h4; f.gap = 4;
      fq.push_back(f);
    end
    dec_mem_wr = 1'b1; dec_mem_rd = 1'b0; dec_reg_wr = 1'b0;
    ack_dly = 10; in_mem_valid = 1'b1;
    wait_state(3'd3, 20, "mem_timeout", n);
    chk("mid_data_write", data_write, 1'b1);
    chk("mid_retired", retired, 16'd1);
    @(negedge clk);
    reset_s = 1'b0; in_mem_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_data_write", data_write, 1'b0);
    chk("mid_rst_state", state, 3'd0);
    chk("mid_rst_retired", retired, 16'd0);
    chk("mid_rst_in_mem_en", in_mem_en, 1'b1);
    @(negedge clk);
    reset_s = 1'b1; dec_mem_wr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("stray_strobes", stray, 0);
    chk("fetch_queue_left", fq.size(), 0);
    chk("wb_queue_left", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
